rr_mux_arbiter: RTL and testbench



---
 rtl/rr_mux_arbiter.sv | 153 +++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter and sequencer for a shared 4:1 mux.
// Four requesters compete for the mux. One requester is granted at a time,
// the grant drives the mux select, and the selected data is registered onto
// o with a valid flag. One requester may hold the grant for at most MAX_HOLD
// consecutive cycles.
//
// Handshake: a requester holds req[k] high for as long as it wants the mux.
// gnt[k] is the registered answer. o/valid follow one edge behind the grant:
// valid=1 means o was sampled from the granted requester's input. Dropping
// req[k] releases the grant at the next edge. There is no ready back-pressure.
module rr_mux_arbiter #(
  parameter int W        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  output logic [3:0]   gnt,
  output logic [1:0]   s,
  output logic [W-1:0] o,
  output logic         valid,
  output logic         busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t       state_q, state_d;
  logic [3:0]   hold_cnt_q, hold_cnt_d;
  logic [1:0]   last_q, last_d;
  logic [3:0]   gnt_q, gnt_d;
  logic [1:0]   s_q, s_d;
  logic [W-1:0] o_q, o_d;
  logic         valid_q, valid_d;
  logic [W-1:0] mux_out;
  logic [1:0]   k;
  logic         rel;

  // First asserted requester after 'from', wrapping; 'from' itself comes last.
  function automatic logic [1:0] pick(input logic [1:0] from, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    pick  = from;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = from + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Shared 4:1 mux under the registered select.
  always_comb begin
    mux_out = I0;
    case (s_q)
      2'd0: mux_out = I0;
      2'd1: mux_out = I1;
      2'd2: mux_out = I2;
      2'd3: mux_out = I3;
      default: mux_out = I0;
    endcase
  end

  // Arbitration FSM: next state, grant, select, hold counter, last owner.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    s_d        = s_q;
    k          = 2'd0;
    rel        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          k          = pick(last_q, req);
          gnt_d      = 4'b0001 << k;
          s_d        = k;
          hold_cnt_d = 4'd1;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // A drop and an expiry on the same edge are one release event.
        rel = !req[s_q] || (hold_cnt_q == HOLD_MAX);
        if (!rel) begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end else begin
          last_d = s_q;
          if (req != 4'b0000) begin
            // Back-to-back handoff; a lone requester is re-granted here.
            k          = pick(s_q, req);
            gnt_d      = 4'b0001 << k;
            s_d        = k;
            hold_cnt_d = 4'd1;
          end else begin
            gnt_d   = 4'b0000;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Output data register: capture the mux only while a grant is active.
  always_comb begin
    o_d     = o_q;
    valid_d = 1'b0;
    if (state_q == GRANT) begin
      o_d     = mux_out;
      valid_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= 4'd0;
      last_q     <= 2'd3;
      gnt_q      <= 4'b0000;
      s_q        <= 2'd0;
      o_q        <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      s_q        <= s_d;
      o_q        <= o_d;
      valid_q    <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign o     = o_q;
  assign valid = valid_q;
  assign busy  = |gnt_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: table-driven vectors plus hand sequences for the
// data-change and asynchronous-reset cases. A second instance with
// MAX_HOLD=1 shares the stimulus and is checked during the all-request run.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] i0, i1, i2, i3;
  logic [3:0] gnt, gnt1;
  logic [1:0] s, s1;
  logic [3:0] o, o1;
  logic       valid, valid1, busy, busy1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst_before;
    logic [3:0] req;
    logic [3:0] i0, i1, i2, i3;
    logic [3:0] gnt;
    logic [1:0] s;
    logic [3:0] o;
    logic       valid;
    logic [3:0] gnt1;
    logic [3:0] o1;
    bit         chk1;
  } vec_t;

  vec_t vq[$];

  rr_mux_arbiter #(.W(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .I0(i0), .I1(i1), .I2(i2), .I3(i3),
    .gnt(gnt), .s(s), .o(o), .valid(valid), .busy(busy)
  );

  rr_mux_arbiter #(.W(4), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .I0(i0), .I1(i1), .I2(i2), .I3(i3),
    .gnt(gnt1), .s(s1), .o(o1), .valid(valid1), .busy(busy1)
  );

  // Clock and initial reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One active edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset, check the cleared outputs, release just after an edge.
  task automatic do_reset();
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b1;
    #1;
    chk("rst_gnt", 8'(gnt), 8'h00);
    chk("rst_valid", 8'(valid), 8'h00);
    chk("rst_o", 8'(o), 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic add(input bit r, input logic [3:0] rq,
                     input logic [3:0] a0, input logic [3:0] a1,
                     input logic [3:0] a2, input logic [3:0] a3,
                     input logic [3:0] eg, input logic [1:0] es,
                     input logic [3:0] eo, input logic ev,
                     input logic [3:0] eg1, input logic [3:0] eo1, input bit c1);
    vec_t v;
    v.rst_before = r; v.req = rq;
    v.i0 = a0; v.i1 = a1; v.i2 = a2; v.i3 = a3;
    v.gnt = eg; v.s = es; v.o = eo; v.valid = ev;
    v.gnt1 = eg1; v.o1 = eo1; v.chk1 = c1;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    i0 = 4'h0; i1 = 4'h1; i2 = 4'h2; i3 = 4'h3;

    // Single requester 2: grant, data, release, valid falls one edge later.
    add(1, 4'b0100, 0, 1, 2, 3, 4'b0100, 2, 4'h0, 0, 0, 0, 0);
    add(0, 4'b0100, 0, 1, 2, 3, 4'b0100, 2, 4'h2, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 2, 3, 4'b0000, 2, 4'h2, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 2, 3, 4'b0000, 2, 4'h2, 0, 0, 0, 0);

    // All four requesting: 4-cycle tenures 0,1,2,3,0; MAX_HOLD=1 rotates each edge.
    for (int e = 1; e <= 18; e++) begin
      int own;
      int od;
      own = ((e - 1) / 4) % 4;
      od  = (e >= 2) ? ((e - 2) / 4) % 4 : 0;
      add(e == 1, 4'b1111, 0, 1, 2, 3, 4'(1 << own), 2'(own), 4'(od), e >= 2,
          4'(1 << ((e - 1) % 4)), 4'((e >= 2) ? (e - 2) % 4 : 0), 1);
    end

    // Early release of requester 0 after 2 cycles, then 1 holds a full 4 without pre-emption.
    add(1, 4'b0011, 0, 1, 2, 3, 4'b0001, 0, 4'h0, 0, 0, 0, 0);
    add(0, 4'b0011, 0, 1, 2, 3, 4'b0001, 0, 4'h0, 1, 0, 0, 0);
    add(0, 4'b0010, 0, 1, 2, 3, 4'b0010, 1, 4'h0, 1, 0, 0, 0);
    add(0, 4'b0011, 0, 1, 2, 3, 4'b0010, 1, 4'h1, 1, 0, 0, 0);
    add(0, 4'b0011, 0, 1, 2, 3, 4'b0010, 1, 4'h1, 1, 0, 0, 0);
    add(0, 4'b0011, 0, 1, 2, 3, 4'b0010, 1, 4'h1, 1, 0, 0, 0);
    add(0, 4'b0011, 0, 1, 2, 3, 4'b0001, 0, 4'h1, 1, 0, 0, 0);

    // Fairness after idle: requester 1 served, released, then 0 wins over 1.
    add(1, 4'b0010, 0, 1, 2, 3, 4'b0010, 1, 4'h0, 0, 0, 0, 0);
    add(0, 4'b0010, 0, 1, 2, 3, 4'b0010, 1, 4'h1, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 2, 3, 4'b0000, 1, 4'h1, 1, 0, 0, 0);
    add(0, 4'b0011, 0, 1, 2, 3, 4'b0001, 0, 4'h1, 0, 0, 0, 0);
    add(0, 4'b0011, 0, 1, 2, 3, 4'b0001, 0, 4'h0, 1, 0, 0, 0);

    foreach (vq[n]) begin
      if (vq[n].rst_before) do_reset();
      req = vq[n].req;
      i0 = vq[n].i0; i1 = vq[n].i1; i2 = vq[n].i2; i3 = vq[n].i3;
      step();
      chk($sformatf("v%0d_gnt", n), 8'(gnt), 8'(vq[n].gnt));
      chk($sformatf("v%0d_s", n), 8'(s), 8'(vq[n].s));
      chk($sformatf("v%0d_o", n), 8'(o), 8'(vq[n].o));
      chk($sformatf("v%0d_valid", n), 8'(valid), 8'(vq[n].valid));
      chk($sformatf("v%0d_busy", n), 8'(busy), 8'(vq[n].gnt != 4'b0000));
      if (vq[n].chk1) begin
        chk($sformatf("v%0d_gnt_h1", n), 8'(gnt1), 8'(vq[n].gnt1));
        chk($sformatf("v%0d_o_h1", n), 8'(o1), 8'(vq[n].o1));
      end
    end

    // Data change under grant, then lone requester 3 re-granted at expiry.
    do_reset();
    i0 = 4'h5; i1 = 4'hA; i2 = 4'h5; i3 = 4'hA;
    req = 4'b1000;
    step();
    chk("dc_gnt1", 8'(gnt), 8'h08);
    chk("dc_s1", 8'(s), 8'h03);
    step();
    chk("dc_o_a", 8'(o), 8'h0A);
    chk("dc_valid2", 8'(valid), 8'h01);
    i3 = 4'hF;
    step();
    chk("dc_o_f", 8'(o), 8'h0F);
    for (int e = 4; e <= 7; e++) begin
      step();
      chk($sformatf("dc_gnt_e%0d", e), 8'(gnt), 8'h08);
      chk($sformatf("dc_valid_e%0d", e), 8'(valid), 8'h01);
      chk($sformatf("dc_o_e%0d", e), 8'(o), 8'h0F);
    end

    // Asynchronous reset between edges while requester 3 holds the grant.
    do_reset();
    i0 = 4'h0; i1 = 4'h1; i2 = 4'h2; i3 = 4'h3;
    req = 4'b1000;
    step();
    step();
    chk("ar_pre_gnt", 8'(gnt), 8'h08);
    chk("ar_pre_o", 8'(o), 8'h03);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_gnt", 8'(gnt), 8'h00);
    chk("ar_s", 8'(s), 8'h00);
    chk("ar_o", 8'(o), 8'h00);
    chk("ar_valid", 8'(valid), 8'h00);
    chk("ar_busy", 8'(busy), 8'h00);
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("ar_next_gnt", 8'(gnt), 8'h01);
    chk("ar_next_s", 8'(s), 8'h00);
    chk("ar_next_valid", 8'(valid), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
